// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM state encodings and
// a small helper for picking the longest pending stall requirement.
package hazard_control_unit_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  function automatic logic [3:0] maxCycles(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_reg_match.sv
// Compares one destination specifier against the ID-stage sources.
// $zero never matches, and Rt only counts when the ID instruction reads it.
module hazard_reg_match #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] destReg,
  input  logic [REG_ADDR_W-1:0] srcRs,
  input  logic [REG_ADDR_W-1:0] srcRt,
  input  logic                  usesRt,
  output logic                  match
);

  always_comb begin
    match = (destReg != '0) && ((destReg == srcRs) || (usesRt && (destReg == srcRt)));
  end

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard controller: zero-latency load-use/branch stall detection,
// multi-cycle stall/flush sequencing and saturating performance counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int FLUSH_CYCLES   = 1,
  parameter int BRANCH_IN_ID   = 0,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  BranchControl,
  input  logic                  IF_ID_Branch,
  input  logic                  IF_ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
  input  logic [REG_ADDR_W-1:0] ID_EX_WriteReg,
  input  logic                  EX_MEM_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_MEM_WriteReg,
  output logic                  Stall,
  output logic                  Flush,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Bubble,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);

  localparam logic [3:0] LU_CYCLES  = 4'(LOAD_USE_STALL);
  localparam logic [3:0] BH2_CYCLES = 4'(LOAD_USE_STALL + 1);
  localparam logic [2:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
  localparam logic       BRANCH_CHECKS = (BRANCH_IN_ID != 0);

  logic [1:0]       stateReg, stateNext;
  logic [2:0]       cntReg, cntNext;
  logic [CNT_W-1:0] stallCountReg, flushCountReg;

  logic matchExLoad, matchExWrite, matchMemWrite;
  logic luHazard, bh1Hazard, bh2Hazard, bh3Hazard, branchInId;
  logic [3:0] needCycles;
  logic stallRaw, flushRaw;

  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) uMatchExLoad (
    .destReg(ID_EX_RegisterRt), .srcRs(IF_ID_RegisterRs), .srcRt(IF_ID_RegisterRt),
    .usesRt(IF_ID_UsesRt), .match(matchExLoad)
  );

  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) uMatchExWrite (
    .destReg(ID_EX_WriteReg), .srcRs(IF_ID_RegisterRs), .srcRt(IF_ID_RegisterRt),
    .usesRt(IF_ID_UsesRt), .match(matchExWrite)
  );

  hazard_reg_match #(.REG_ADDR_W(REG_ADDR_W)) uMatchMemWrite (
    .destReg(EX_MEM_WriteReg), .srcRs(IF_ID_RegisterRs), .srcRt(IF_ID_RegisterRt),
    .usesRt(IF_ID_UsesRt), .match(matchMemWrite)
  );

  always_comb begin
    branchInId = BRANCH_CHECKS && IF_ID_Branch;
    luHazard   = ID_EX_MemRead && matchExLoad;
    bh1Hazard  = branchInId && ID_EX_RegWrite && !ID_EX_MemRead && matchExWrite;
    bh2Hazard  = branchInId && ID_EX_MemRead && matchExLoad;
    bh3Hazard  = branchInId && EX_MEM_MemRead && matchMemWrite;
    // Several hazards may coincide; the longest requirement wins.
    needCycles = maxCycles(luHazard ? LU_CYCLES : 4'd0, bh2Hazard ? BH2_CYCLES : 4'd0);
    needCycles = maxCycles(needCycles, (bh1Hazard || bh3Hazard) ? 4'd1 : 4'd0);
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    stallRaw  = 1'b0;
    flushRaw  = 1'b0;
    // A taken branch overrides whatever the FSM was doing, including a stall.
    if (BranchControl) begin
      flushRaw = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        stateNext = FLUSH;
        cntNext   = FLUSH_RELOAD;
      end else begin
        stateNext = IDLE;
        cntNext   = 3'd0;
      end
    end else begin
      case (stateReg)
        IDLE: begin
          if (needCycles != 4'd0) begin
            stallRaw = 1'b1;
            if (needCycles > 4'd1) begin
              stateNext = STALL;
              cntNext   = 3'(needCycles - 4'd2);
            end
          end
        end
        STALL: begin
          stallRaw = 1'b1;
          if (cntReg == 3'd0) stateNext = IDLE;
          else                cntNext   = cntReg - 3'd1;
        end
        FLUSH: begin
          flushRaw = 1'b1;
          if (cntReg == 3'd0) stateNext = IDLE;
          else                cntNext   = cntReg - 3'd1;
        end
        default: begin
          stateNext = IDLE;
          cntNext   = 3'd0;
        end
      endcase
    end
  end

  // Outputs drop to their idle values the instant reset asserts.
  always_comb begin
    Stall        = stallRaw & reset;
    Flush        = flushRaw & reset;
    PCWrite      = ~Stall;
    IF_ID_Write  = ~Stall;
    ID_EX_Bubble = Stall | Flush;
    StallCount   = stallCountReg;
    FlushCount   = flushCountReg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg      <= IDLE;
      cntReg        <= 3'd0;
      stallCountReg <= '0;
      flushCountReg <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (Stall && !(&stallCountReg))         stallCountReg <= stallCountReg + 1'b1;
      if (BranchControl && !(&flushCountReg)) flushCountReg <= flushCountReg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: four parameterisations share one
// set of inputs; each sequence checks the instance it targets.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       BranchControl, IF_ID_Branch, IF_ID_UsesRt;
  logic [4:0] IF_ID_RegisterRs, IF_ID_RegisterRt;
  logic       ID_EX_MemRead, ID_EX_RegWrite;
  logic [4:0] ID_EX_RegisterRt, ID_EX_WriteReg;
  logic       EX_MEM_MemRead;
  logic [4:0] EX_MEM_WriteReg;

  logic        stl[4], fls[4], pcw[4], ifw[4], bub[4];
  logic [15:0] sc0, fc0, sc1, fc1, sc2, fc2;
  logic [3:0]  sc3, fc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // d0: defaults
  hazard_control_unit d0 (
    .clk(clk), .reset(reset), .BranchControl(BranchControl), .IF_ID_Branch(IF_ID_Branch),
    .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_WriteReg(ID_EX_WriteReg), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .Stall(stl[0]), .Flush(fls[0]), .PCWrite(pcw[0]), .IF_ID_Write(ifw[0]), .ID_EX_Bubble(bub[0]),
    .StallCount(sc0), .FlushCount(fc0));

  // d1: 3-cycle load-use, 2-cycle flush
  hazard_control_unit #(.LOAD_USE_STALL(3), .FLUSH_CYCLES(2)) d1 (
    .clk(clk), .reset(reset), .BranchControl(BranchControl), .IF_ID_Branch(IF_ID_Branch),
    .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_WriteReg(ID_EX_WriteReg), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .Stall(stl[1]), .Flush(fls[1]), .PCWrite(pcw[1]), .IF_ID_Write(ifw[1]), .ID_EX_Bubble(bub[1]),
    .StallCount(sc1), .FlushCount(fc1));

  // d2: branches resolve in ID
  hazard_control_unit #(.BRANCH_IN_ID(1)) d2 (
    .clk(clk), .reset(reset), .BranchControl(BranchControl), .IF_ID_Branch(IF_ID_Branch),
    .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_WriteReg(ID_EX_WriteReg), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .Stall(stl[2]), .Flush(fls[2]), .PCWrite(pcw[2]), .IF_ID_Write(ifw[2]), .ID_EX_Bubble(bub[2]),
    .StallCount(sc2), .FlushCount(fc2));

  // d3: 4-bit counters
  hazard_control_unit #(.CNT_W(4)) d3 (
    .clk(clk), .reset(reset), .BranchControl(BranchControl), .IF_ID_Branch(IF_ID_Branch),
    .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .ID_EX_WriteReg(ID_EX_WriteReg), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .Stall(stl[3]), .Flush(fls[3]), .PCWrite(pcw[3]), .IF_ID_Write(ifw[3]), .ID_EX_Bubble(bub[3]),
    .StallCount(sc3), .FlushCount(fc3));

  typedef struct {
    logic       memRead;
    logic [4:0] exRt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       expStall;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s: %0d", name, actual);
    end
  endtask

  task automatic clearInputs();
    BranchControl = 0; IF_ID_Branch = 0; IF_ID_UsesRt = 0;
    IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
    ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_RegisterRt = 0; ID_EX_WriteReg = 0;
    EX_MEM_MemRead = 0; EX_MEM_WriteReg = 0;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  // Each step: move to the falling edge, caller drives inputs, sample 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd6, 5'd5, 5'd6, 1'b1, 1'b1};

    clearInputs();
    reset = 0;
    #1;
    doReset();
    #1;
    check("reset_stall", stl[0], 0);
    check("reset_flush", fls[0], 0);
    check("reset_pcwrite", pcw[0], 1);
    check("reset_ifidwrite", ifw[0], 1);
    check("reset_bubble", bub[0], 0);
    check("reset_stallcount", sc0, 0);
    check("reset_flushcount", fc0, 0);

    // Basic load-use on default instance
    step();
    ID_EX_MemRead = 1; ID_EX_RegisterRt = 5; IF_ID_RegisterRs = 5;
    #1;
    check("lu_stall", stl[0], 1);
    check("lu_pcwrite", pcw[0], 0);
    check("lu_bubble", bub[0], 1);
    step();
    ID_EX_MemRead = 0;
    #1;
    check("lu_release", stl[0], 0);
    check("lu_stallcount", sc0, 1);

    // Table of single-cycle match patterns on the default instance
    doReset();
    for (int i = 0; i < 6; i++) begin
      step();
      clearInputs();
      ID_EX_MemRead = vecs[i].memRead; ID_EX_RegisterRt = vecs[i].exRt;
      IF_ID_RegisterRs = vecs[i].rs; IF_ID_RegisterRt = vecs[i].rt; IF_ID_UsesRt = vecs[i].usesRt;
      #1;
      check($sformatf("vec%0d_stall", i), stl[0], vecs[i].expStall);
      check($sformatf("vec%0d_pcwrite", i), pcw[0], !vecs[i].expStall);
    end
    step();
    clearInputs();
    #1;
    check("vec_stallcount", sc0, 3);

    // Multi-cycle load-use stall
    doReset();
    step();
    ID_EX_MemRead = 1; ID_EX_RegisterRt = 5; IF_ID_RegisterRs = 5;
    #1;
    check("lus3_c0", stl[1], 1);
    step(); clearInputs(); #1;
    check("lus3_c1", stl[1], 1);
    step(); #1;
    check("lus3_c2", stl[1], 1);
    step(); #1;
    check("lus3_c3", stl[1], 0);
    check("lus3_stallcount", sc1, 3);

    // Branch aborts a stall, then a 2-cycle flush
    doReset();
    step();
    ID_EX_MemRead = 1; ID_EX_RegisterRt = 5; IF_ID_RegisterRs = 5;
    #1;
    check("abort_c0_stall", stl[1], 1);
    step(); clearInputs(); BranchControl = 1; #1;
    check("abort_c1_stall", stl[1], 0);
    check("abort_c1_flush", fls[1], 1);
    check("abort_c1_bubble", bub[1], 1);
    step(); BranchControl = 0; #1;
    check("abort_c2_flush", fls[1], 1);
    check("abort_c2_stall", stl[1], 0);
    step(); #1;
    check("abort_c3_flush", fls[1], 0);
    check("abort_flushcount", fc1, 1);
    check("abort_stallcount", sc1, 1);

    // Branch-in-ID hazards
    doReset();
    step();
    IF_ID_Branch = 1; IF_ID_RegisterRs = 9; ID_EX_RegWrite = 1; ID_EX_WriteReg = 9;
    #1;
    check("bh1_stall", stl[2], 1);
    check("bh1_default_nostall", stl[0], 0);
    step(); clearInputs(); #1;
    check("bh1_release", stl[2], 0);
    step();
    IF_ID_Branch = 1; IF_ID_RegisterRs = 9; ID_EX_RegWrite = 1; ID_EX_MemRead = 1;
    ID_EX_RegisterRt = 9; ID_EX_WriteReg = 9;
    #1;
    check("bh2_c0", stl[2], 1);
    step(); clearInputs(); #1;
    check("bh2_c1", stl[2], 1);
    step(); #1;
    check("bh2_c2", stl[2], 0);
    step();
    IF_ID_Branch = 1; IF_ID_RegisterRs = 9; EX_MEM_MemRead = 1; EX_MEM_WriteReg = 9;
    #1;
    check("bh3_stall", stl[2], 1);
    step(); clearInputs(); #1;
    check("bh3_release", stl[2], 0);
    check("bh_stallcount", sc2, 4);

    // Saturation and asynchronous reset mid-stall
    doReset();
    step();
    ID_EX_MemRead = 1; ID_EX_RegisterRt = 5; IF_ID_RegisterRs = 5;
    repeat (20) step();
    #1;
    check("sat_stallcount", sc3, 15);
    check("sat_stall_held", stl[3], 1);
    #1;
    reset = 0;
    #1;
    check("async_rst_stall", stl[3], 0);
    check("async_rst_pcwrite", pcw[3], 1);
    check("async_rst_stallcount", sc3, 0);
    clearInputs();
    step();
    reset = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
